mem_arbiter: RTL

- Shares the single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) in the multi-cycle NPC.
- Each requester has independent valid/ready request and response channels. Exactly one transaction is outstanding on the memory side at a time.
- A registered request slot and a 4-state FSM sequence accept → issue → wait → respond.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU (read-only) and the
// LSU (read/write). One transaction is in flight at a time, sequenced by
// IDLE -> ISSUE -> WAIT -> RESP.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration on ties
// (default build: fixed LSU priority).
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;

    state_t state;
    state_t state_nxt;
    owner_t owner;
    logic   grant_ifu;
    logic   grant_lsu;
    logic   accept;

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;

    // Round-robin: a tie goes to whoever was not granted last.
    always_comb begin
        grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant == OWN_IFU));
        grant_ifu = ifu_req_valid && !grant_lsu;
    end

    // Remember the most recent winner; IFU after reset so LSU takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_IFU;
        end else if (accept) begin
            last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
        end
    end
`else
    // Fixed priority: the LSU always wins a tie.
    always_comb begin
        grant_lsu = lsu_req_valid;
        grant_ifu = ifu_req_valid && !lsu_req_valid;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; readies are held low while in reset.
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    ifu_req_ready = grant_ifu;
                    lsu_req_ready = grant_lsu;
                    if (grant_ifu || grant_lsu) begin
                        accept    = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (owner == OWN_LSU) begin
                    lsu_resp_valid = 1'b1;
                    if (lsu_resp_ready) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    ifu_resp_valid = 1'b1;
                    if (ifu_resp_ready) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request slot and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_IFU;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            ifu_rdata <= '0;
            lsu_rdata <= '0;
        end else begin
            if (accept) begin
                if (grant_lsu) begin
                    owner     <= OWN_LSU;
                    mem_addr  <= lsu_addr;
                    mem_wen   <= lsu_wen;
                    mem_wdata <= lsu_wdata;
                    mem_wmask <= lsu_wen ? lsu_wmask : MASK_W'(0);
                end else begin
                    owner     <= OWN_IFU;
                    mem_addr  <= ifu_addr;
                    mem_wen   <= 1'b0;
                    mem_wdata <= '0;
                    mem_wmask <= '0;
                end
            end
            if ((state == WAIT) && mem_resp_valid) begin
                if (owner == OWN_LSU) begin
                    lsu_rdata <= mem_wen ? DATA_W'(0) : mem_rdata;
                end else begin
                    ifu_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
